// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_STALL    = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } haz_state_t;

    localparam int DEF_REG_AW        = 5;
    localparam int DEF_CNT_W         = 2;
    localparam int DEF_LU_STALL      = 1;
    localparam int DEF_BR_ALU_STALL  = 1;
    localparam int DEF_BR_LOAD_STALL = 2;

    // A load that already reached MEM is one cycle from forwarding into the ID comparator
    localparam int BR_MEMLOAD_STALL  = 1;

    // Register $zero is hard-wired, so it can never be the source of a hazard
    localparam int REG_ZERO          = 0;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard comparator: returns how many stall cycles the
// instruction currently in ID needs, given the EX and MEM stage producers.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW        = DEF_REG_AW,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LU_STALL      = DEF_LU_STALL,
    parameter int BR_ALU_STALL  = DEF_BR_ALU_STALL,
    parameter int BR_LOAD_STALL = DEF_BR_LOAD_STALL
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] idex_dst,
    input  logic              idex_reg_write,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] exmem_dst,
    input  logic              exmem_mem_read,
    output logic [CNT_W-1:0]  stallCount
);

    logic exMatch;
    logic memMatch;
    int   needCycles;

    // Does the ID instruction read the register being produced in EX or MEM
    always_comb begin
        exMatch  = (idex_dst != REG_AW'(REG_ZERO)) &&
                   ((idex_dst == id_rs) || (id_uses_rt && (idex_dst == id_rt)));
        memMatch = (exmem_dst != REG_AW'(REG_ZERO)) &&
                   ((exmem_dst == id_rs) || (id_uses_rt && (exmem_dst == id_rt)));
    end

    // Take the longest stall demanded by any matching producer
    always_comb begin
        needCycles = 0;
        if (idex_mem_read && exMatch)
            needCycles = maxOf(needCycles, LU_STALL);
        if (id_branch && idex_reg_write && !idex_mem_read && exMatch)
            needCycles = maxOf(needCycles, BR_ALU_STALL);
        if (id_branch && idex_mem_read && exMatch)
            needCycles = maxOf(needCycles, BR_LOAD_STALL);
        if (id_branch && exmem_mem_read && memMatch)
            needCycles = maxOf(needCycles, BR_MEMLOAD_STALL);
        stallCount = CNT_W'(needCycles);
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for the 5-stage MIPS core: counted stalls for load-use and
// branch-operand hazards, one-cycle squash on taken branches, and a full freeze
// while data memory is busy. Define HAZARD_STATS_EN to build the statistic
// counters; otherwise the statistic ports read zero.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW        = DEF_REG_AW,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LU_STALL      = DEF_LU_STALL,
    parameter int BR_ALU_STALL  = DEF_BR_ALU_STALL,
    parameter int BR_LOAD_STALL = DEF_BR_LOAD_STALL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] idex_dst,
    input  logic              idex_reg_write,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] exmem_dst,
    input  logic              exmem_mem_read,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       wait_cycles
);

    haz_state_t       state;
    haz_state_t       retState;
    haz_state_t       effState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hazardN;
    logic             memWait;

    hazard_detect #(
        .REG_AW        (REG_AW),
        .CNT_W         (CNT_W),
        .LU_STALL      (LU_STALL),
        .BR_ALU_STALL  (BR_ALU_STALL),
        .BR_LOAD_STALL (BR_LOAD_STALL)
    ) uDetect (
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_branch      (id_branch),
        .idex_dst       (idex_dst),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .exmem_dst      (exmem_dst),
        .exmem_mem_read (exmem_mem_read),
        .stallCount     (hazardN)
    );

    // The cycle memory finally answers behaves exactly like the state we froze in
    always_comb begin
        memWait  = mem_req && !mem_ready;
        effState = (state == HZ_MEM_WAIT) ? retState : state;
    end

    // Sequencer state: memory freeze dominates, then the stall countdown, then new hazards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HZ_RUN;
            retState <= HZ_RUN;
            cnt      <= '0;
        end else if (memWait) begin
            if (state != HZ_MEM_WAIT)
                retState <= state;
            state <= HZ_MEM_WAIT;
        end else if (effState == HZ_STALL) begin
            cnt   <= cnt - CNT_W'(1);
            state <= (cnt == CNT_W'(1)) ? HZ_RUN : HZ_STALL;
        end else if (hazardN > CNT_W'(1)) begin
            cnt   <= hazardN - CNT_W'(1);
            state <= HZ_STALL;
        end else begin
            state <= HZ_RUN;
        end
    end

    // Pipeline register controls derived from the current state and this cycle's hazards
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst || memWait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if ((effState == HZ_STALL) || (hazardN != '0)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_branch && br_taken) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCycles;
    logic [31:0] flushCount;
    logic [31:0] waitCycles;

    // Free-running event counters for performance analysis
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles <= '0;
            flushCount  <= '0;
            waitCycles  <= '0;
        end else begin
            if (idex_bubble)
                stallCycles <= stallCycles + 32'd1;
            if (ifid_flush)
                flushCount <= flushCount + 32'd1;
            if (memWait)
                waitCycles <= waitCycles + 32'd1;
        end
    end

    assign stall_cycles = stallCycles;
    assign flush_cnt    = flushCount;
    assign wait_cycles  = waitCycles;
`else
    assign stall_cycles = 32'd0;
    assign flush_cnt    = 32'd0;
    assign wait_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed pipeline scenarios followed
// by randomized traffic, all judged against a cycle-level reference model.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    localparam logic [5:0] PAT_IDLE  = 6'b111100;
    localparam logic [5:0] PAT_STALL = 6'b001101;
    localparam logic [5:0] PAT_FLUSH = 6'b111110;
    localparam logic [5:0] PAT_OFF   = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, idex_dst, exmem_dst;
    logic        id_uses_rt, id_branch, br_taken;
    logic        idex_reg_write, idex_mem_read, exmem_mem_read;
    logic        mem_req, mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble;
    logic [31:0] stall_cycles, flush_cnt, wait_cycles;

    int checks   = 0;
    int failures = 0;

    int pending  = 0;
    int mStall   = 0;
    int mFlush   = 0;
    int mWait    = 0;

    hazard_ctrl_unit dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_branch      (id_branch),
        .br_taken       (br_taken),
        .idex_dst       (idex_dst),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .exmem_dst      (exmem_dst),
        .exmem_mem_read (exmem_mem_read),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .stall_cycles   (stall_cycles),
        .flush_cnt      (flush_cnt),
        .wait_cycles    (wait_cycles)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The ID instruction reads register d, and d is not $zero
    function automatic bit reads(input logic [4:0] d);
        return (d != 5'd0) && ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    // Stall cycles demanded by the current operand configuration
    function automatic int hazardCycles();
        int n;
        n = 0;
        if (idex_mem_read && reads(idex_dst) && n < 1) n = 1;
        if (id_branch && idex_reg_write && !idex_mem_read && reads(idex_dst) && n < 1) n = 1;
        if (id_branch && idex_mem_read && reads(idex_dst) && n < 2) n = 2;
        if (id_branch && exmem_mem_read && reads(exmem_dst) && n < 1) n = 1;
        return n;
    endfunction

    task automatic clearInputs();
        rst = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0; br_taken = 1'b0;
        idex_dst = 5'd0; idex_reg_write = 1'b0; idex_mem_read = 1'b0;
        exmem_dst = 5'd0; exmem_mem_read = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Inputs are already driven (just after a falling edge); judge this cycle, then advance
    task automatic applyStimulus(input string tag);
        logic [5:0] exp;
        int n;
        #1;
        if (rst) begin
            pending = 0;
            mStall = 0;
            mFlush = 0;
            mWait = 0;
        end
        checkOutput({tag, "/stall_cycles"}, stall_cycles, STATS_EN ? mStall : 0);
        checkOutput({tag, "/flush_cnt"}, flush_cnt, STATS_EN ? mFlush : 0);
        checkOutput({tag, "/wait_cycles"}, wait_cycles, STATS_EN ? mWait : 0);
        if (rst) begin
            exp = PAT_OFF;
        end else if (mem_req && !mem_ready) begin
            exp = PAT_OFF;
            mWait++;
        end else if (pending > 0) begin
            exp = PAT_STALL;
            pending--;
            mStall++;
        end else begin
            n = hazardCycles();
            if (n > 0) begin
                exp = PAT_STALL;
                pending = n - 1;
                mStall++;
            end else if (id_branch && br_taken) begin
                exp = PAT_FLUSH;
                mFlush++;
            end else begin
                exp = PAT_IDLE;
            end
        end
        checkOutput({tag, "/ctl"},
                    {26'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble},
                    {26'd0, exp});
        @(negedge clk);
    endtask

    // Sequence: reset, directed pipeline scenarios, randomized traffic, summary
    initial begin
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        applyStimulus("reset0");
        applyStimulus("reset1");
        rst = 1'b0;
        applyStimulus("idle");

        // lw $2 in EX, add reading $2 in ID
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd2; id_rs = 5'd2;
        applyStimulus("loaduse");
        clearInputs();
        applyStimulus("loaduse_after");

        // lw $3 in EX, beq reading $3 through rt
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd3;
        id_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd3; id_rs = 5'd1; br_taken = 1'b1;
        applyStimulus("brload_s1");
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_dst = 5'd0;
        exmem_mem_read = 1'b1; exmem_dst = 5'd3;
        applyStimulus("brload_s2");
        exmem_mem_read = 1'b0; exmem_dst = 5'd0;
        applyStimulus("brload_flush");
        clearInputs();
        applyStimulus("brload_after");

        // Writer of $0 never creates a hazard
        idex_reg_write = 1'b1; idex_dst = 5'd0; id_rs = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd0;
        applyStimulus("zero_reg");
        clearInputs();

        // Memory freeze in the middle of a two-cycle branch stall
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd3;
        id_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd3;
        applyStimulus("wait_s1");
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_dst = 5'd0;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("wait_held");
        mem_ready = 1'b1;
        applyStimulus("wait_resume");
        clearInputs();
        applyStimulus("wait_after");

        // Reset while frozen on memory
        mem_req = 1'b1; mem_ready = 1'b0;
        applyStimulus("rstwait_w1");
        applyStimulus("rstwait_w2");
        rst = 1'b1;
        applyStimulus("rstwait_rst");
        clearInputs();
        applyStimulus("rstwait_after");

        // Two load-use stalls and one taken branch for the statistic counters
        for (int i = 0; i < 2; i++) begin
            idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd5; id_rs = 5'd5;
            applyStimulus("stats_lu");
            clearInputs();
        end
        id_branch = 1'b1; br_taken = 1'b1;
        applyStimulus("stats_br");
        clearInputs();
        applyStimulus("stats_end");

        // Randomized traffic over a small register set so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_uses_rt     = 1'($urandom_range(0, 1));
            id_branch      = ($urandom_range(0, 9) < 4);
            br_taken       = 1'($urandom_range(0, 1));
            idex_dst       = 5'($urandom_range(0, 3));
            idex_reg_write = 1'($urandom_range(0, 1));
            idex_mem_read  = ($urandom_range(0, 9) < 3);
            exmem_dst      = 5'($urandom_range(0, 3));
            exmem_mem_read = ($urandom_range(0, 9) < 3);
            mem_req        = ($urandom_range(0, 9) < 3);
            mem_ready      = ($urandom_range(0, 9) < 5);
            applyStimulus("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
